// File: rtl/ysyx_22040237_div_seq_if.sv
// Request/result handshake between the EXU and the sequential RV64M divider.
// The master side is the EXU; the slave side is the divider sequencer.
interface ysyx_22040237_div_seq_if #(
    parameter int XLEN = 64
);
    logic            div_valid_i;
    logic            div_ready_o;
    logic [1:0]      div_op_i;
    logic            div_wop_i;
    logic [XLEN-1:0] div_dividend_i;
    logic [XLEN-1:0] div_divisor_i;
    logic            flush_i;
    logic            res_valid_o;
    logic            res_ready_i;
    logic [XLEN-1:0] res_o;
    logic            busy_o;

    modport master (
        output div_valid_i, div_op_i, div_wop_i, div_dividend_i, div_divisor_i,
        output flush_i, res_ready_i,
        input  div_ready_o, res_valid_o, res_o, busy_o
    );

    modport slave (
        input  div_valid_i, div_op_i, div_wop_i, div_dividend_i, div_divisor_i,
        input  flush_i, res_ready_i,
        output div_ready_o, res_valid_o, res_o, busy_o
    );
endinterface

// File: rtl/ysyx_22040237_div_seq.sv
// Radix-2 restoring divider sequencer for div/divu/rem/remu and their word forms.
// Define YSYX_22040237_DIV_FASTPATH_EN to resolve trivial divides at the accept edge.
module ysyx_22040237_div_seq #(
    parameter int XLEN = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22040237_div_seq_if.slave dif
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            rem_sel;
    logic            wop_q;
    logic            q_neg;
    logic            r_neg;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dsr;

    // Word results always carry bit 31 into the upper half, unsigned word ops included.
    function automatic logic [XLEN-1:0] word_fmt(input logic [XLEN-1:0] v, input logic w);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    logic            sgn;
    logic            a_neg;
    logic            b_neg;
    logic            b_zero;
    logic [XLEN-1:0] a_ext;
    logic [XLEN-1:0] b_ext;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;

    always_comb begin
        sgn   = ~dif.div_op_i[0];
        a_ext = dif.div_dividend_i;
        b_ext = dif.div_divisor_i;
        if (dif.div_wop_i) begin
            a_ext = {{(XLEN-32){sgn & dif.div_dividend_i[31]}}, dif.div_dividend_i[31:0]};
            b_ext = {{(XLEN-32){sgn & dif.div_divisor_i[31]}}, dif.div_divisor_i[31:0]};
        end
        a_neg  = sgn & a_ext[XLEN-1];
        b_neg  = sgn & b_ext[XLEN-1];
        b_zero = (b_ext == '0);
        a_abs  = a_neg ? -a_ext : a_ext;
        b_abs  = b_neg ? -b_ext : b_ext;
    end

`ifdef YSYX_22040237_DIV_FASTPATH_EN
    logic            ovf;
    logic            fast;
    logic [XLEN-1:0] fast_q;
    logic [XLEN-1:0] fast_r;

    // MIN / -1 yields MIN, which is the sign-extended dividend itself.
    always_comb begin
        ovf = sgn & (b_ext == '1) &
              (a_ext == (dif.div_wop_i ? {{(XLEN-32){1'b1}}, 32'h8000_0000}
                                       : {1'b1, {(XLEN-1){1'b0}}}));
        fast   = b_zero | ovf | (a_abs < b_abs);
        fast_q = '0;
        fast_r = a_ext;
        if (b_zero) begin
            fast_q = '1;
        end else if (ovf) begin
            fast_q = a_ext;
            fast_r = '0;
        end
    end
`endif

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] q_fin;
    logic [XLEN-1:0] r_fin;
    logic            ready;

    assign shifted = {rem, quo[XLEN-1]};
    assign trial   = shifted - {1'b0, dsr};
    assign q_fin   = q_neg ? -quo : quo;
    assign r_fin   = r_neg ? -rem : rem;
    assign ready   = (state == IDLE) & ~rst;

    assign dif.div_ready_o = ready;
    assign dif.busy_o      = (state != IDLE);

    // Word ops park the 32 dividend bits at the top so the same shift path serves both widths.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            dif.res_valid_o <= 1'b0;
            dif.res_o       <= '0;
        end else if (dif.flush_i) begin
            state           <= IDLE;
            dif.res_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dif.div_valid_i) begin
                        rem_sel <= dif.div_op_i[1];
                        wop_q   <= dif.div_wop_i;
                        q_neg   <= (a_neg ^ b_neg) & ~b_zero;
                        r_neg   <= a_neg;
                        rem     <= '0;
                        dsr     <= b_abs;
                        quo     <= dif.div_wop_i ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
                        cnt     <= dif.div_wop_i ? CW'(32) : CW'(XLEN);
`ifdef YSYX_22040237_DIV_FASTPATH_EN
                        if (fast) begin
                            dif.res_o <= word_fmt(dif.div_op_i[1] ? fast_r : fast_q, dif.div_wop_i);
                            state     <= DONE;
                        end else
`endif
                        begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                    quo <= {quo[XLEN-2:0], ~trial[XLEN]};
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    dif.res_o       <= word_fmt(rem_sel ? r_fin : q_fin, wop_q);
                    dif.res_valid_o <= 1'b1;
                    state           <= DONE;
                end
                DONE: begin
                    if (dif.res_valid_o && dif.res_ready_i) begin
                        dif.res_valid_o <= 1'b0;
                        state           <= IDLE;
                    end else begin
                        dif.res_valid_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
